// File: rtl/dfi2dp_pipe.sv
// dfi2dp_pipe: registered DFI-to-PHY word/phase remapper with a write-data delay line,
// per-lane RX deskew FIFOs and an external pass-through mode.
module dfi2dp_pipe #(
    parameter int NUM_DQ    = 2,
    parameter int NUM_PH    = 8,
    parameter int DQ_WIDTH  = 8,
    parameter int CA_WIDTH  = 6,
    parameter int MAX_WRDLY = 7,
    parameter int RDF_DEPTH = 4
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_txrx_mode,
    input  logic [$clog2(MAX_WRDLY+1)-1:0]              i_wrdly,
    input  logic [NUM_PH-1:0]                           i_dfi_cke,
    input  logic [NUM_PH-1:0]                           i_dfi_cs,
    input  logic [NUM_PH*CA_WIDTH-1:0]                  i_dfi_ca,
    input  logic [NUM_DQ*NUM_PH*DQ_WIDTH-1:0]           i_dfi_wrdata,
    input  logic [NUM_DQ*NUM_PH-1:0]                    i_dfi_wrdata_mask,
    output logic [NUM_DQ*NUM_PH*DQ_WIDTH-1:0]           o_dfi_rddata,
    output logic [NUM_DQ*NUM_PH-1:0]                    o_dfi_rddata_dbi,
    output logic [NUM_PH-1:0]                           o_dfi_rddata_valid,
    input  logic [NUM_DQ*NUM_PH-1:0]                    i_tx_dqs_sdr,
    input  logic [NUM_PH-1:0]                           i_tx_ck_sdr,
    input  logic [NUM_DQ*NUM_PH*(DQ_WIDTH+1)-1:0]       i_tx_sdr,
    output logic [NUM_DQ*NUM_PH*(DQ_WIDTH+1)-1:0]       o_rx_sdr,
    input  logic [NUM_DQ*NUM_PH-1:0]                    i_tx_ck_ext_sdr,
    output logic [NUM_DQ*NUM_PH-1:0]                    o_rx_sdr_vld,
    output logic [NUM_DQ*NUM_PH*(DQ_WIDTH+1)-1:0]       o_dq_sdr,
    input  logic [NUM_DQ*NUM_PH*(DQ_WIDTH+1)-1:0]       i_dq_sdr,
    input  logic [NUM_DQ*NUM_PH-1:0]                    i_dq_sdr_vld,
    output logic [NUM_DQ*NUM_PH-1:0]                    o_dqs_sdr,
    output logic [NUM_PH*(CA_WIDTH+2)-1:0]              o_ca_sdr,
    output logic [NUM_PH-1:0]                           o_ck_sdr,
    output logic                                        o_rdf_ovf,
    output logic                                        o_rdf_mis
);
    localparam int W  = DQ_WIDTH + 1;
    localparam int C  = CA_WIDTH + 2;
    localparam int DW = $clog2(MAX_WRDLY + 1);
    localparam int AW = $clog2(RDF_DEPTH);
    localparam int LW = NUM_PH * W;
    localparam int FW = NUM_PH + LW;

    logic                              r_mode;
    logic                              w_tog;
    logic [DW-1:0]                     w_dly;
    logic [NUM_DQ*LW-1:0]              w_wr_wop;
    logic [NUM_PH*C-1:0]               w_ca_wop;
    logic [NUM_DQ*LW-1:0]              r_dly [1:MAX_WRDLY];
    logic [NUM_DQ*LW-1:0]              w_line [0:MAX_WRDLY];
    logic [NUM_DQ-1:0]                 w_ne;
    logic [NUM_DQ-1:0]                 w_full;
    logic [NUM_DQ-1:0]                 w_push;
    logic [NUM_DQ*FW-1:0]              w_heads;
    logic                              w_pop;
    logic                              w_ovf;
    logic                              w_mis;
    logic [NUM_DQ*NUM_PH*DQ_WIDTH-1:0] w_rd_pow;
    logic [NUM_DQ*NUM_PH-1:0]          w_rd_dbi;

    // Any edge of the mode input, seen against last cycle's copy, flushes RX and the write line.
    assign w_tog = i_txrx_mode ^ r_mode;
    assign w_dly = (i_wrdly > DW'(MAX_WRDLY)) ? DW'(MAX_WRDLY) : i_wrdly;
    assign w_pop = (&w_ne) && !w_tog;
    assign w_ovf = (|(w_push & w_full)) && !w_pop && !w_tog;

    always_comb begin
        w_wr_wop = '0;
        w_ca_wop = '0;
        for (int l = 0; l < NUM_DQ; l++)
            for (int p = 0; p < NUM_PH; p++) begin
                for (int w = 0; w < DQ_WIDTH; w++)
                    w_wr_wop[l*LW + w*NUM_PH + p] = i_dfi_wrdata[(l*NUM_PH + p)*DQ_WIDTH + w];
                w_wr_wop[l*LW + DQ_WIDTH*NUM_PH + p] = i_dfi_wrdata_mask[l*NUM_PH + p];
            end
        for (int p = 0; p < NUM_PH; p++) begin
            for (int w = 0; w < CA_WIDTH; w++)
                w_ca_wop[w*NUM_PH + p] = i_dfi_ca[p*CA_WIDTH + w];
            w_ca_wop[CA_WIDTH*NUM_PH + p]     = i_dfi_cs[p];
            w_ca_wop[(CA_WIDTH+1)*NUM_PH + p] = i_dfi_cke[p];
        end
    end

    // Tap 0 is the undelayed word, so a zero delay still gives one cycle of latency.
    always_comb begin
        w_line[0] = w_wr_wop;
        for (int k = 1; k <= MAX_WRDLY; k++)
            w_line[k] = r_dly[k];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode       <= 1'b0;
            o_dq_sdr     <= '0;
            o_dqs_sdr    <= '0;
            o_ca_sdr     <= '0;
            o_ck_sdr     <= '0;
            o_rx_sdr     <= '0;
            o_rx_sdr_vld <= '0;
            for (int k = 1; k <= MAX_WRDLY; k++)
                r_dly[k] <= '0;
        end else begin
            r_mode       <= i_txrx_mode;
            o_dq_sdr     <= i_txrx_mode ? i_tx_sdr : w_line[w_dly];
            o_dqs_sdr    <= i_txrx_mode ? i_tx_ck_ext_sdr : i_tx_dqs_sdr;
            o_ca_sdr     <= w_ca_wop;
            o_ck_sdr     <= i_tx_ck_sdr;
            o_rx_sdr     <= i_dq_sdr;
            o_rx_sdr_vld <= i_dq_sdr_vld;
            for (int k = 1; k <= MAX_WRDLY; k++)
                r_dly[k] <= w_tog ? '0 : w_line[k-1];
        end
    end

    for (genvar l = 0; l < NUM_DQ; l++) begin : g_rdf
        logic [AW:0]         r_wp;
        logic [AW:0]         r_rp;
        logic [FW-1:0]       r_mem [RDF_DEPTH];
        logic [NUM_PH-1:0]   w_vld;
        assign w_vld     = i_dq_sdr_vld[l*NUM_PH +: NUM_PH];
        assign w_push[l] = (|w_vld) && !i_txrx_mode;
        assign w_ne[l]   = r_wp != r_rp;
        assign w_full[l] = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
        assign w_heads[l*FW +: FW] = r_mem[r_rp[AW-1:0]];
        // Pop frees the head slot before the push lands, so a full FIFO can accept a write.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_wp <= '0;
                r_rp <= '0;
                for (int i = 0; i < RDF_DEPTH; i++)
                    r_mem[i] <= '0;
            end else if (w_tog) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                if (w_push[l] && (!w_full[l] || w_pop)) begin
                    r_mem[r_wp[AW-1:0]] <= {w_vld, i_dq_sdr[l*LW +: LW]};
                    r_wp                <= r_wp + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_pow = '0;
        w_rd_dbi = '0;
        w_mis    = 1'b0;
        for (int l = 0; l < NUM_DQ; l++) begin
            w_mis = w_mis | (w_heads[l*FW + LW +: NUM_PH] != w_heads[LW +: NUM_PH]);
            for (int p = 0; p < NUM_PH; p++) begin
                for (int w = 0; w < DQ_WIDTH; w++)
                    w_rd_pow[(l*NUM_PH + p)*DQ_WIDTH + w] = w_heads[l*FW + w*NUM_PH + p];
                w_rd_dbi[l*NUM_PH + p] = w_heads[l*FW + DQ_WIDTH*NUM_PH + p];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dfi_rddata       <= '0;
            o_dfi_rddata_dbi   <= '0;
            o_dfi_rddata_valid <= '0;
            o_rdf_ovf          <= 1'b0;
            o_rdf_mis          <= 1'b0;
        end else begin
            o_dfi_rddata_valid <= w_pop ? w_heads[LW +: NUM_PH] : '0;
            if (w_pop) begin
                o_dfi_rddata     <= w_rd_pow;
                o_dfi_rddata_dbi <= w_rd_dbi;
            end
            if (w_ovf)
                o_rdf_ovf <= 1'b1;
            if (w_pop && w_mis)
                o_rdf_mis <= 1'b1;
        end
    end
endmodule
